// File: rtl/clock_period_meter.sv
// clock_period_meter: measures period and high time of a slow asynchronous input in clk_in cycles
module clock_period_meter #(
  parameter int COUNT_WIDTH = 24,
  parameter int TIMEOUT_MAX = 10_000_000
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   sig_in,
  output logic [COUNT_WIDTH-1:0] period,
  output logic [COUNT_WIDTH-1:0] high_time,
  output logic                   period_valid,
  output logic                   timeout
);
  typedef enum logic [1:0] {IDLE, MEASURE, LOST} state_t;
  localparam logic [COUNT_WIDTH-1:0] TMAX = COUNT_WIDTH'(TIMEOUT_MAX);
  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);
  state_t state_q, state_d;
  logic s1_q, s2_q, prev_q;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, hi_q, hi_d, period_q, period_d, high_q, high_d;
  logic valid_q, valid_d, timeout_q, timeout_d;
  logic rise;
  assign rise = s2_q & ~prev_q;
  assign period = period_q;
  assign high_time = high_q;
  assign period_valid = valid_q;
  assign timeout = timeout_q;
  // synchronizer, edge flop and all measurement state
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      prev_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      period_q <= '0;
      high_q <= '0;
      valid_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      prev_q <= s2_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      period_q <= period_d;
      high_q <= high_d;
      valid_q <= valid_d;
      timeout_q <= timeout_d;
    end
  end
  // next state: a rise publishes the running counts, a full count without a rise declares loss
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    period_d = period_q;
    high_d = high_q;
    valid_d = 1'b0;
    timeout_d = timeout_q;
    if (state_q == MEASURE) begin
      if (rise) begin
        period_d = cnt_q;
        high_d = hi_q;
        valid_d = 1'b1;
        timeout_d = 1'b0;
        cnt_d = ONE;
        hi_d = ONE;
      end else if (cnt_q == TMAX) begin
        state_d = LOST;
        timeout_d = 1'b1;
        period_d = '0;
        high_d = '0;
      end else begin
        cnt_d = cnt_q + ONE;
        hi_d = hi_q + COUNT_WIDTH'(s2_q);
      end
    end else if (rise) begin
      state_d = MEASURE;
      cnt_d = ONE;
      hi_d = ONE;
    end
  end
endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter: scoreboard bench for clock_period_meter
module tb_clock_period_meter;
  logic clk_in = 1'b0, reset = 1'b1, sig_in = 1'b0;
  logic [15:0] period, high_time;
  logic period_valid, timeout;
  int passes = 0, total = 0;
  typedef struct packed {logic [15:0] p; logic [15:0] h; logic t;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  clock_period_meter #(.COUNT_WIDTH(16), .TIMEOUT_MAX(20)) dut (
    .clk_in(clk_in), .reset(reset), .sig_in(sig_in), .period(period),
    .high_time(high_time), .period_valid(period_valid), .timeout(timeout)
  );
  always #5 clk_in = ~clk_in;
  always @(negedge clk_in) begin
    if (!reset && period_valid) begin
      total++;
      if (exp_q.size() == 0) $display("FAIL unexpected_valid: got period=%0d high_time=%0d, required no pulse", period, high_time);
      else begin
        e = exp_q.pop_front();
        if ({period, high_time, timeout} == {e.p, e.h, e.t}) passes++;
        else $display("FAIL report: got period=%0d high_time=%0d timeout=%0d, required %0d/%0d/%0d", period, high_time, timeout, e.p, e.h, e.t);
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got == want) passes++;
    else $display("FAIL %s: got %0d required %0d", name, got, want);
  endtask
  task automatic push(input int p, input int h, input int n);
    repeat (n) exp_q.push_back('{16'(p), 16'(h), 1'b0});
  endtask
  task automatic hold(input logic v, input int n);
    sig_in = v;
    repeat (n) @(negedge clk_in);
  endtask
  task automatic wave(input int h, input int l, input int n);
    repeat (n) begin
      hold(1'b1, h);
      hold(1'b0, l);
    end
  endtask
  initial begin
    #1;
    chk("rst_period", 32'(period), 0);
    chk("rst_high", 32'(high_time), 0);
    chk("rst_valid", 32'(period_valid), 0);
    chk("rst_timeout", 32'(timeout), 0);
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    hold(1'b0, 3);
    push(8, 4, 4);
    wave(4, 4, 5);
    push(8, 4, 1);
    push(10, 3, 3);
    wave(3, 7, 4);
    push(10, 3, 1);
    push(12, 6, 1);
    wave(6, 6, 2);
    push(12, 6, 1);
    hold(1'b1, 4);
    hold(1'b0, 18);
    chk("timeout_early", 32'(timeout), 0);
    @(negedge clk_in);
    chk("timeout_set", 32'(timeout), 1);
    chk("lost_period", 32'(period), 0);
    chk("lost_high", 32'(high_time), 0);
    hold(1'b0, 2);
    hold(1'b1, 4);
    chk("timeout_hold_rise", 32'(timeout), 1);
    hold(1'b0, 4);
    push(8, 4, 2);
    wave(4, 4, 2);
    chk("timeout_cleared", 32'(timeout), 0);
    hold(1'b0, 30);
    chk("timeout_again", 32'(timeout), 1);
    push(20, 10, 3);
    wave(10, 10, 3);
    hold(1'b1, 10);
    chk("boundary_no_timeout", 32'(timeout), 0);
    hold(1'b0, 11);
    hold(1'b1, 3);
    chk("over_timeout", 32'(timeout), 1);
    chk("over_period", 32'(period), 0);
    hold(1'b1, 7);
    hold(1'b0, 10);
    push(20, 10, 1);
    hold(1'b1, 4);
    chk("recover_timeout", 32'(timeout), 0);
    hold(1'b0, 30);
    push(8, 4, 2);
    wave(4, 4, 2);
    hold(1'b1, 4);
    hold(1'b0, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_period", 32'(period), 0);
    chk("mid_rst_high", 32'(high_time), 0);
    chk("mid_rst_valid", 32'(period_valid), 0);
    chk("mid_rst_timeout", 32'(timeout), 0);
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    hold(1'b0, 4);
    push(8, 4, 2);
    wave(4, 4, 3);
    push(8, 4, 1);
    sig_in = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("latency_k1", 32'(period_valid), 0);
    @(negedge clk_in);
    chk("latency_k2", 32'(period_valid), 1);
    @(negedge clk_in);
    chk("latency_one_cycle", 32'(period_valid), 0);
    hold(1'b1, 1);
    hold(1'b0, 10);
    chk("pending_reports", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
